// File: rtl/storage_probe_seq.sv
// Purpose : shifts a captured bit pattern onto d and scores the latch / posedge-FF / negedge-FF outputs.
// Latency : d is registered; q_a and q_c are judged 1 edge after d changes, q_b 2 edges after.
// Backpressure: none; start is taken only in IDLE, and a start while busy is dropped (not queued).
//
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : run request (IDLE only)
//   pattern, len     : stimulus bits (bit i in run cycle i) and length; both captured at start
//   q_a, q_b, q_c    : latch, posedge flop and negedge flop outputs of the unit under test
//   d                : registered stimulus to the unit under test
//   busy, done, pass : status; done is a one-cycle pulse; pass is valid after done
//   err_a/b/c        : saturating mismatch counters, held until the next accepted start
module storage_probe_seq #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 5,
  localparam int LEN_W = $clog2(PAT_W) + 1,
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             q_a,
  input  logic             q_b,
  input  logic             q_c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_a,
  output logic [CNT_W-1:0] err_b,
  output logic [CNT_W-1:0] err_c,
  output logic             pass
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic               drain_q;
  // d_q/dv_q is the bit on d this cycle (h0/v0); h1_q/hv1_q is the bit from one cycle earlier.
  logic               d_q;
  logic               dv_q;
  logic               h1_q;
  logic               hv1_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [CNT_W-1:0]   err_a_q, err_b_q, err_c_q;
  logic [CNT_W-1:0]   err_a_d, err_b_d, err_c_d;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   idx_nxt;
  logic [LEN_W-1:0]   idx_last;
  logic               chk_en;

  // Zero or oversize lengths collapse to a full-width run.
  always_comb begin
    len_eff = len;
    if ((len == '0) || (len > LEN_W'(PAT_W))) begin
      len_eff = LEN_W'(PAT_W);
    end
  end

  assign idx_nxt  = idx_q + LEN_W'(1);
  assign idx_last = len_q - LEN_W'(1);
  assign chk_en   = (state_q != ST_IDLE);

  // The valid flags keep DRAIN zeros and idle values out of the score.
  always_comb begin
    err_a_d = err_a_q;
    err_b_d = err_b_q;
    err_c_d = err_c_q;
    if (chk_en && dv_q && (q_a != d_q) && (err_a_q != CNT_MAX)) begin
      err_a_d = err_a_q + CNT_W'(1);
    end
    if (chk_en && dv_q && (q_c != d_q) && (err_c_q != CNT_MAX)) begin
      err_c_d = err_c_q + CNT_W'(1);
    end
    if (chk_en && hv1_q && (q_b != h1_q) && (err_b_q != CNT_MAX)) begin
      err_b_d = err_b_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      drain_q <= 1'b0;
      d_q     <= 1'b0;
      dv_q    <= 1'b0;
      h1_q    <= 1'b0;
      hv1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_a_q <= '0;
      err_b_q <= '0;
      err_c_q <= '0;
    end else begin
      h1_q    <= d_q;
      hv1_q   <= dv_q;
      done_q  <= 1'b0;
      err_a_q <= err_a_d;
      err_b_q <= err_b_d;
      err_c_q <= err_c_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pat_q   <= pattern;
            len_q   <= len_eff;
            idx_q   <= '0;
            d_q     <= pattern[0];
            dv_q    <= 1'b1;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_a_q <= '0;
            err_b_q <= '0;
            err_c_q <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (idx_q == idx_last) begin
            d_q     <= 1'b0;
            dv_q    <= 1'b0;
            drain_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            idx_q <= idx_nxt;
            d_q   <= pat_q[idx_nxt[IDX_W-1:0]];
          end
        end
        ST_DRAIN: begin
          // Two DRAIN cycles let the last run bit reach the q_b check.
          if (drain_q) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        ST_DONE: begin
          pass_q  <= (err_a_d == '0) && (err_b_d == '0) && (err_c_d == '0);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign d     = d_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pass  = pass_q;
  assign err_a = err_a_q;
  assign err_b = err_b_q;
  assign err_c = err_c_q;

endmodule

// File: doc/storage_probe_seq.md
# storage_probe_seq

Stimulus sequencer and checker for the storage-element comparison unit, which holds a D latch (enable = clk), a posedge D flip-flop and a negedge D flip-flop on one shared `d`. On a start pulse it shifts a programmable bit pattern onto `d`, one bit per clock. It samples the three outputs `q_a`, `q_b` and `q_c` at fixed latencies and counts mismatches per element. It sits in the storage-element test harness and drives the `d` input of the comparison unit directly.

## Interface
Parameters:
- `PAT_W`, default 16: pattern length capacity in bits.
- `CNT_W`, default 5: width of each error counter; counters saturate.

Ports:
- `clk`, input, 1: single clock; all logic is posedge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: run request; sampled only in IDLE.
- `pattern`, input, PAT_W: bit i is driven on `d` in run cycle i; captured at start.
- `len`, input, $clog2(PAT_W)+1: number of bits to drive; captured at start. Values 0 and >PAT_W are treated as PAT_W.
- `q_a`, input, 1: latch output.
- `q_b`, input, 1: posedge flip-flop output.
- `q_c`, input, 1: negedge flip-flop output.
- `d`, output, 1: registered stimulus to the comparison unit.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `done`, output, 1: one-cycle pulse in DONE.
- `err_a`, output, CNT_W: `q_a` mismatch count.
- `err_b`, output, CNT_W: `q_b` mismatch count.
- `err_c`, output, CNT_W: `q_c` mismatch count.
- `pass`, output, 1: registered; set in DONE when all three counters are 0, cleared at start.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DRAIN after the last bit.
  - DRAIN → DONE after 2 cycles.
  - DONE → IDLE after 1 cycle.
- Start acceptance, on the IDLE edge with `start`=1:
  - capture `pattern`, the effective length L, and idx=0;
  - clear `err_a`, `err_b`, `err_c` and `pass`;
  - `d` <= `pattern[0]`.
- `start` while busy is ignored. It is not queued.
- RUN:
  - each edge, idx increments and `d` <= `pattern[idx]`;
  - on the edge where idx = L-1 completes, go to DRAIN with `d` <= 0.
- Expected-value tracking, a 2-deep history of driven bits with valid flags:
  - h0/v0 = bit driven in the previous cycle;
  - h1/v1 = bit driven two cycles back;
  - v is set only for run bits, so DRAIN zeros are never checked.
- Checks, every edge in RUN, DRAIN and DONE:
  - `q_a` ≠ h0 with v0 → `err_a`++;
  - `q_c` ≠ h0 with v0 → `err_c`++;
  - `q_b` ≠ h1 with v1 → `err_b`++.
- Counters saturate at 2^CNT_W−1. They hold their value from DONE until the next accepted start.
- DONE: `done`=1 for exactly one cycle; `pass` <= (all counters, including any final increment, = 0).

## Timing
- Reset values: `d`=0, `busy`=0, `done`=0, `pass`=0, `err_*`=0, state=IDLE, history and valids cleared.
- Reset asserted mid-run aborts on that edge; no `done` pulse is produced.
- Latency from the edge where `d` changes:
  - `q_a` (latch closes at negedge) and `q_c` are checked 1 edge later;
  - `q_b` is checked 2 edges later.
- Busy duration: `busy` rises the cycle after start acceptance and lasts L+3 cycles (L RUN, 2 DRAIN, 1 DONE).
- The last run bit is checked for `q_b` in the second DRAIN cycle.
- Start is accepted again on the first IDLE edge after DONE, so back-to-back runs are possible with a 1-cycle IDLE gap.
- Boundary cases:
  - L=1 gives RUN for one cycle;
  - `len`=0 runs PAT_W bits;
  - `pattern` changes after start have no effect.

## Test plan
- Reset, then `start` with `pattern`=16'hA5C3, `len`=16, healthy unit: `d` = LSB-first A5C3, `busy` high for 19 cycles, `done` pulses once, `err_*`=0, `pass`=1.
- Force `q_b` stuck at 0, `pattern`=16'hFFFF, `len`=8: `err_b`=8, `err_a`=0, `err_c`=0, `pass`=0.
- Force `q_c` stuck at 1, `pattern`=0, `len`=0 (runs 16 bits), CNT_W=3: `err_c` saturates at 7, `pass`=0.
- `len`=1, `pattern`=1: `d`=1 for exactly 1 cycle, `busy` high for 4 cycles; `err_b` check occurs in the second DRAIN cycle and counts 0.
- Pulse `start` again at cycle 5 of a run: ignored; run ends at its original time and counters are not cleared.
- Assert `rst_n`=0 at RUN idx 6: next cycle state=IDLE, `d`=0, counters 0, no `done` pulse; a fresh start then runs normally.
